// File: rtl/sr_channel_arbiter_pkg.sv
// rtl/sr_channel_arbiter_pkg.sv - shared types and defaults for the receive_send channel arbiter
//
// Purpose: word sizing, arbiter defaults, FSM state type and a small
// round-robin pointer helper shared by the arbiter and its picker.
// Ports: none (package).

package sr_channel_arbiter_pkg;

  // One vh_arr word is vl_word_size+1 bits wide.
  localparam int vl_word_size = 3;
  typedef logic [vl_word_size:0] vh_arr;

  localparam int SR_NUM_REQ      = 4;
  localparam int SR_MAX_BURST    = 4;
  localparam int SR_WORD_W       = vl_word_size + 1;
  localparam int SR_IDLE_TIMEOUT = 8;

  typedef enum logic {IDLE, GRANTED} sr_state_t;

  typedef logic [SR_NUM_REQ-1:0] sr_req_vec_t;

  // Next round-robin start position after agent idx, modulo n.
  function automatic int sr_wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sr_channel_arbiter_rr_pick.sv
// rtl/sr_channel_arbiter_rr_pick.sv - combinational round-robin picker
//
// Purpose: returns the first set request bit found scanning upward from ptr,
// wrapping modulo N. Purely combinational so other arbiters can reuse it.
// Ports:
//   req   in  N   request vector
//   ptr   in  PW  scan start position
//   sel   out N   one-hot selected requester (zero when none)
//   idx   out PW  binary index of the selected requester
//   found out 1   at least one request was set

module sr_channel_arbiter_rr_pick #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  sel,
  output logic [PW-1:0] idx,
  output logic          found
);

  // One extra bit so ptr+k can exceed N-1 before the modulo fold.
  localparam int JW = PW + 1;

  logic [JW-1:0] pos;

  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + JW'(k);
      if (pos >= JW'(N)) begin
        pos = pos - JW'(N);
      end
      if (!found && req[pos[PW-1:0]]) begin
        found             = 1'b1;
        sel[pos[PW-1:0]]  = 1'b1;
        idx               = pos[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/sr_channel_arbiter.sv
// rtl/sr_channel_arbiter.sv - round-robin burst arbiter in front of receive_send
//
// Purpose: shares the single receive_send data input among NUM_REQ sender
// agents. One agent owns the channel at a time for a burst that ends on
// req_last, after MAX_BURST beats, or after IDLE_TIMEOUT idle cycles.
// Ports:
//   clk        in  1                system clock, rising edge
//   rst        in  1                synchronous active-high reset
//   req_valid  in  NUM_REQ          per-agent word valid
//   req_last   in  NUM_REQ          per-agent end-of-burst, qualified by req_valid
//   req_data   in  NUM_REQ*WORD_W   agent i word at [i*WORD_W +: WORD_W]
//   req_ready  out NUM_REQ          per-agent ready, only the owner's bit can be high
//   chan_valid out 1                word valid toward receive_send
//   chan_data  out WORD_W           word toward receive_send
//   chan_ready in  1                channel accepts the word
//   grant      out NUM_REQ          registered one-hot owner
//   busy       out 1                registered, high while GRANTED

module sr_channel_arbiter
  import sr_channel_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = SR_NUM_REQ,
  parameter int WORD_W       = SR_WORD_W,
  parameter int MAX_BURST    = SR_MAX_BURST,
  parameter int IDLE_TIMEOUT = SR_IDLE_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*WORD_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        chan_valid,
  output logic [WORD_W-1:0]           chan_data,
  input  logic                        chan_ready,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  sr_state_t      state;
  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  owner;
  logic [BW-1:0]  beat_cnt;
  logic [7:0]     idle_cnt;

  logic [NUM_REQ-1:0] pick_sel;
  logic [PW-1:0]      pick_idx;
  logic               pick_found;

  logic own_valid;
  logic own_last;
  logic beat;
  logic burst_done;
  logic idle_expired;

  sr_channel_arbiter_rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .sel   (pick_sel),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // grant is all-zero outside GRANTED, so masking with it gives the IDLE
  // behaviour (no valid, no ready, zero data) without decoding state here.
  assign own_valid  = |(req_valid & grant);
  assign own_last   = |(req_last & grant);
  assign chan_valid = own_valid;
  assign req_ready  = grant & {NUM_REQ{chan_ready}};

  always_comb begin
    chan_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        chan_data = req_data[i*WORD_W +: WORD_W];
      end
    end
  end

  // A stall (valid without ready) is neither a beat nor an idle cycle.
  assign beat         = own_valid & chan_ready;
  assign burst_done   = beat & (own_last | (beat_cnt == BW'(MAX_BURST - 1)));
  assign idle_expired = !own_valid && (idle_cnt == 8'(IDLE_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      busy     <= 1'b0;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= GRANTED;
            grant    <= pick_sel;
            busy     <= 1'b1;
            owner    <= pick_idx;
            beat_cnt <= '0;
            idle_cnt <= '0;
          end
        end

        GRANTED: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
          if (own_valid) begin
            idle_cnt <= '0;
          end else if (idle_cnt != 8'hFF) begin
            idle_cnt <= idle_cnt + 8'd1;
          end
          // Release always passes through IDLE, giving the one-cycle bubble
          // between grants even when the same agent asks again.
          if (burst_done || idle_expired) begin
            state  <= IDLE;
            grant  <= '0;
            busy   <= 1'b0;
            rr_ptr <= PW'(sr_wrap_inc(int'(owner), NUM_REQ));
          end
        end

        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_channel_arbiter.sv
// tb/tb_sr_channel_arbiter.sv - scoreboard bench for sr_channel_arbiter

module tb_sr_channel_arbiter;
  import sr_channel_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int W  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_last;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            chan_valid;
  logic [W-1:0]    chan_data;
  logic            chan_ready;
  logic [NR-1:0]   grant;
  logic            busy;

  sr_channel_arbiter #(
    .NUM_REQ(NR), .WORD_W(W), .MAX_BURST(4), .IDLE_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .chan_valid(chan_valid), .chan_data(chan_data), .chan_ready(chan_ready),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef logic [W:0] word_t;
  typedef struct { int owner; logic [W-1:0] d; } xfer_t;
  typedef struct { logic [NR-1:0] g; int plen; bit lat; } gev_t;

  word_t aq [NR][$];
  xfer_t exp_x[$];
  gev_t  exp_g[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int rise_cyc [NR];
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event not as required (cycle %0d)", name, cyc);
  endtask

  function automatic int oh_idx(input logic [NR-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic send(input int a, input logic [W-1:0] d, input bit last);
    aq[a].push_back({last, d});
  endtask

  task automatic expx(input int a, input logic [W-1:0] d);
    exp_x.push_back('{a, d});
  endtask

  task automatic expg(input logic [NR-1:0] g, input int plen, input bit lat);
    exp_g.push_back('{g, plen, lat});
  endtask

  // Agent driver: heads of the per-agent queues are presented until handshaked.
  initial begin
    logic [NR-1:0] hs;
    logic [NR-1:0] nv;
    word_t         w;
    word_t         dummy;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < NR; i++) rise_cyc[i] = 0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #2;
      nv = '0;
      for (int i = 0; i < NR; i++) begin
        if (hs[i] && aq[i].size() > 0) dummy = aq[i].pop_front();
        if (aq[i].size() > 0) begin
          w = aq[i][0];
          nv[i] = 1'b1;
          req_data[i*W +: W] = w[W-1:0];
          req_last[i] = w[W];
          if (!req_valid[i]) rise_cyc[i] = cyc;
        end else begin
          req_last[i] = 1'b0;
        end
      end
      req_valid = nv;
    end
  end

  // Monitor: invariants, channel scoreboard, grant-change scoreboard.
  initial begin
    logic [NR-1:0]   prev_g;
    logic [NR-1:0]   pv, phs;
    logic [NR*W-1:0] pdata;
    logic [NR-1:0]   plast;
    int              hold;
    bit              started;
    xfer_t           x;
    gev_t            e;
    started = 1'b0;
    prev_g = '0; pv = '0; phs = '0; pdata = '0; plast = '0; hold = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!started) begin
          prev_g = grant;
          hold = 0;
          started = 1'b1;
        end
        chk("grant_onehot0", int'($onehot0(grant)), 1);
        chk("ready_in_grant", int'(req_ready & ~grant), 0);
        chk("ready_model", req_ready, chan_ready ? grant : '0);
        chk("busy_model", busy, int'(|grant));
        chk("valid_model", chan_valid, int'(|(req_valid & grant)));
        chk("valid_when_idle", int'(!busy && chan_valid), 0);
        for (int i = 0; i < NR; i++) begin
          if (pv[i] && !phs[i] && req_valid[i]) begin
            chk("req_stable", {req_last[i], req_data[i*W +: W]}, {plast[i], pdata[i*W +: W]});
          end
        end
        if (chan_valid && chan_ready) begin
          if (exp_x.size() == 0) begin
            fail("unexpected_word");
          end else begin
            x = exp_x.pop_front();
            chk("chan_data", chan_data, x.d);
            chk("chan_owner", grant, 1 << x.owner);
          end
        end
        if (grant != prev_g) begin
          if (exp_g.size() == 0) begin
            fail("unexpected_grant");
          end else begin
            e = exp_g.pop_front();
            chk("grant", grant, e.g);
            if (e.plen != 0) chk("grant_hold", hold, e.plen);
            if (e.lat) chk("req_to_grant", cyc - rise_cyc[oh_idx(grant)], 1);
          end
          prev_g = grant;
          hold = 1;
        end else begin
          hold++;
        end
        pv = req_valid;
        phs = req_valid & req_ready;
        pdata = req_data;
        plast = req_last;
      end
    end
  end

  task automatic wait_idle();
    int  k;
    bit  empty;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      empty = (exp_x.size() == 0) && (exp_g.size() == 0) && (grant == '0);
      for (int i = 0; i < NR; i++) if (aq[i].size() != 0) empty = 1'b0;
      if (empty) break;
    end
    if (k == 300) fail("wait_idle_timeout");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input logic [NR-1:0] g);
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (grant == g) break;
    end
    if (k == 50) chk("wait_grant", grant, g);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    chan_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_chan_valid", chan_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_chan_data", chan_data, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Single agent, burst ended by last.
    @(posedge clk); #1;
    send(0, 4'h3, 0); send(0, 4'h5, 0); send(0, 4'hA, 1);
    expx(0, 4'h3); expx(0, 4'h5); expx(0, 4'hA);
    expg(4'b0001, 0, 1); expg(4'b0000, 3, 0);
    wait_idle();

    // MAX_BURST cut, regrant, then idle-timeout release.
    for (int d = 1; d <= 6; d++) begin
      send(2, W'(d), 0);
      expx(2, W'(d));
    end
    expg(4'b0100, 0, 1); expg(4'b0000, 4, 0);
    expg(4'b0100, 1, 0); expg(4'b0000, 10, 0);
    wait_idle();

    // Round-robin from rr_ptr=0 after a reset pulse.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send(0, 4'h8, 1); send(0, 4'h9, 1);
    send(1, 4'hB, 1); send(2, 4'hC, 1); send(3, 4'hD, 1);
    expx(0, 4'h8); expx(1, 4'hB); expx(2, 4'hC); expx(3, 4'hD); expx(0, 4'h9);
    expg(4'b0001, 0, 1); expg(4'b0000, 1, 0);
    expg(4'b0010, 1, 0); expg(4'b0000, 1, 0);
    expg(4'b0100, 1, 0); expg(4'b0000, 1, 0);
    expg(4'b1000, 1, 0); expg(4'b0000, 1, 0);
    expg(4'b0001, 1, 0); expg(4'b0000, 1, 0);
    wait_idle();

    // Channel backpressure for 5 granted cycles.
    chan_ready = 1'b0;
    send(1, 4'h6, 0); send(1, 4'h7, 0); send(1, 4'hE, 1);
    expx(1, 4'h6); expx(1, 4'h7); expx(1, 4'hE);
    expg(4'b0010, 0, 1); expg(4'b0000, 8, 0);
    wait_grant(4'b0010);
    repeat (5) @(posedge clk);
    #1;
    chan_ready = 1'b1;
    wait_idle();

    // Idle timeout with agent 0 pending.
    send(3, 4'h4, 0); send(0, 4'h5, 1);
    expx(3, 4'h4); expx(0, 4'h5);
    expg(4'b1000, 0, 1); expg(4'b0000, 9, 0);
    expg(4'b0001, 1, 0); expg(4'b0000, 1, 0);
    wait_idle();

    // Reset mid-burst after two beats.
    send(1, 4'h1, 0); send(1, 4'h2, 0); send(1, 4'h3, 0); send(1, 4'h4, 0);
    expx(1, 4'h1); expx(1, 4'h2);
    expg(4'b0010, 0, 1); expg(4'b0000, 3, 0);
    wait_grant(4'b0010);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    chan_ready = 1'b0;
    aq[1].delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chan_ready = 1'b1;
    chk("midrst_grant", grant, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_chan_valid", chan_valid, 0);
    send(3, 4'hF, 1);
    expx(3, 4'hF);
    expg(4'b1000, 0, 1); expg(4'b0000, 1, 0);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sr_channel_arbiter.md
Name: sr_channel_arbiter

Overview:
- Shares the single receive_send channel among NUM_REQ sender agents.
- Grants the channel round-robin, one agent at a time, for a bounded burst of words.
- Uses a valid/ready handshake on each requester and on the channel side.
- Sits between the sender agents and the receive_send instance. It drives that instance's data input and adds flow control the bare datapath lacks.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WORD_W, vl_word_size+1 (=4), width of one vh_arr word.
- MAX_BURST, 4, maximum handshaked words per grant (1..15).
- IDLE_TIMEOUT, 8, consecutive granted cycles with req_valid low before forced release (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-agent request/data valid.
- req_last  in  NUM_REQ  per-agent end-of-burst marker, qualified by req_valid.
- req_data  in  NUM_REQ*WORD_W  packed agent words; agent i occupies bits [i*WORD_W +: WORD_W].
- req_ready  out  NUM_REQ  per-agent ready; at most one bit high.
- chan_valid  out  1  word valid toward receive_send.
- chan_data  out  WORD_W  word toward receive_send.
- chan_ready  in  1  channel accepts word.
- grant  out  NUM_REQ  one-hot current owner, registered.
- busy  out  1  high while in GRANTED.

Behaviour:
- Reset: synchronous, active-high, on the clk edge where rst=1. All outputs are 0 after reset. State=IDLE. rr_ptr=0. beat_cnt=0. idle_cnt=0. rst dominates every other event.
- Reset mid-burst: grant drops on the next edge. Words not yet handshaked are not transferred. No partial-burst recovery.
- States: IDLE, GRANTED.
- IDLE:
  - grant=0, busy=0, chan_valid=0, req_ready=0.
  - If any req_valid is high, select the first set bit scanning upward from rr_ptr, wrapping modulo NUM_REQ.
  - Next edge: grant=onehot(sel), state=GRANTED, beat_cnt=0, idle_cnt=0.
  - Request-to-grant latency is 1 cycle.
- GRANTED (owner g):
  - chan_valid = req_valid[g]. chan_data = req_data[g], combinational mux.
  - req_ready[g] = chan_ready. All other req_ready bits are 0.
- Beat: a cycle with req_valid[g] & chan_ready. On each beat, beat_cnt increments.
- Release, checked in priority order:
  - (a) Beat with req_last[g]=1.
  - (b) Beat where beat_cnt==MAX_BURST-1.
  - (c) idle_cnt reaches IDLE_TIMEOUT-1 while req_valid[g]=0.
- On release, next edge: state=IDLE, grant=0, rr_ptr=(g+1) mod NUM_REQ.
  - Exactly one bubble cycle separates consecutive grants, including when the same agent requests again.
- idle_cnt increments each GRANTED cycle with req_valid[g]=0. It clears on any cycle with req_valid[g]=1.
- chan_ready low with req_valid[g] high is a stall. Owner keeps the grant. Neither counter advances. There is no timeout on channel backpressure.
- Requests from non-owners are ignored, never lost. Arbitration sees them at the next IDLE.
- Fairness: with all agents continuously requesting, grants cycle 0,1,2,3,0,...
  - Worst-case wait = (NUM_REQ-1)*(MAX_BURST+1) cycles, with chan_ready held high.
- Counter widths: beat_cnt is $clog2(MAX_BURST+1) bits; idle_cnt is 8 bits. Neither counter wraps; both are cleared on grant.
- Assertions the bench checks:
  - grant is one-hot or zero.
  - req_ready is a subset of grant.
  - chan_valid=0 whenever busy=0.
- The protocol requires req_data/req_last to stay stable while req_valid=1 and no beat has occurred. Violations are flagged by the bench, not the RTL.

Decomposition:
- Shared package common_vl_pack gets:
  - SR_NUM_REQ=4, SR_MAX_BURST=4.
  - typedef sr_state_t enum {IDLE, GRANTED}.
  - typedef sr_req_vec_t logic [SR_NUM_REQ-1:0].
- WORD_W derives from vl_word_size. The word type stays vh_arr from common_vh_pack.
- One natural sub-module: rr_pick. It is combinational: takes the request vector and rr_ptr and returns a one-hot select plus a found flag. It is reusable by other arbiters in the design.

Test Plan:
- Reset mid-burst: agent 1 granted, 2 beats done, assert rst 1 cycle -> grant=0, busy=0, chan_valid=0 next cycle; rr_ptr=0, so next single request from agent 3 is granted 1 cycle after rst drops.
- Single agent, burst with last: agent 0 sends 0x3,0x5,0xA, last on 0xA, chan_ready=1 -> grant=0001 1 cycle after req, chan_data 3,5,A on consecutive cycles, grant=0 on the cycle after 0xA.
- MAX_BURST cut: agent 2 streams 6 words, no last -> 4 words pass, 1-cycle gap with grant=0, regrant to agent 2, remaining 2 words pass.
- Round-robin: all 4 agents request continuously, 1-word bursts with last -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
- Backpressure: agent 1 granted, chan_ready=0 for 5 cycles with valid high -> grant held, req_ready[1]=0, beat_cnt unchanged; transfer completes when chan_ready=1.
- Idle timeout: agent 3 granted then drops req_valid -> grant released after 8 cycles; pending agent 0 granted on the 2nd cycle after release.
